// File: rtl/lsu_dbus_ctrl_pkg.sv
// rtl/lsu_dbus_ctrl_pkg.sv - shared LSU/data-bus types, funct3 codes and decode helpers
package lsu_dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_RESP = 2'd2
  } type_lsu_states_e;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        w_en;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

  function automatic logic lsu_illegal(input logic w_en, input logic [2:0] funct3);
    if (w_en) return (funct3 > LSU_SW);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] a);
    return ((funct3[1:0] == 2'b01) && a[0]) || ((funct3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  function automatic logic [31:0] lsu_force_align(input logic [2:0] funct3, input logic [31:0] addr);
    case (funct3[1:0])
      2'b01:   return {addr[31:1], 1'b0};
      2'b10:   return {addr[31:2], 2'b00};
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dbus_ctrl_if.sv
// rtl/lsu_dbus_ctrl_if.sv - LSU to dmem/peripheral bus bundle
interface lsu_dbus_ctrl_if;
  lsu_dbus_ctrl_pkg::type_dbus2peri_s lsu2dbus_o;
  lsu_dbus_ctrl_pkg::type_peri2dbus_s dbus2lsu_i;
  logic                               dmem_sel;
  logic                               store_busy;

  modport master (
    output lsu2dbus_o,
    output dmem_sel,
    input  dbus2lsu_i,
    input  store_busy
  );

  modport slave (
    input  lsu2dbus_o,
    input  dmem_sel,
    output dbus2lsu_i,
    output store_busy
  );
endinterface

// File: rtl/lsu_dbus_ctrl_align.sv
// rtl/lsu_dbus_ctrl_align.sv - byte-lane select, store shift and load extract/extend
module lsu_dbus_ctrl_align
  import lsu_dbus_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  a_i,
  input  logic [31:0] w_data_i,
  input  logic [31:0] r_data_i,
  output logic [3:0]  sel_byte_o,
  output logic [31:0] w_data_o,
  output logic [31:0] r_data_o
);

  logic [31:0] r_shift;

  assign r_shift  = r_data_i >> {a_i, 3'b000};
  assign w_data_o = w_data_i << {a_i, 3'b000};

  always_comb begin
    sel_byte_o = 4'b1111;
    case (funct3_i[1:0])
      2'b00:   sel_byte_o = 4'b0001 << a_i;
      2'b01:   sel_byte_o = 4'b0011 << {a_i[1], 1'b0};
      default: sel_byte_o = 4'b1111;
    endcase
  end

  always_comb begin
    r_data_o = '0;
    case (funct3_i)
      LSU_LB:  r_data_o = {{24{r_shift[7]}}, r_shift[7:0]};
      LSU_LH:  r_data_o = {{16{r_shift[15]}}, r_shift[15:0]};
      LSU_LW:  r_data_o = r_shift;
      LSU_LBU: r_data_o = {24'd0, r_shift[7:0]};
      LSU_LHU: r_data_o = {16'd0, r_shift[15:0]};
      default: r_data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// rtl/lsu_dbus_ctrl.sv - load/store unit sequencing dmem RMW stores and peripheral accesses
// Optional feature: LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of forcing alignment).
module lsu_dbus_ctrl
  import lsu_dbus_ctrl_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE    = 32'h0000_0000,
  parameter logic [31:0] DMEM_MASK    = 32'hFFC0_0000,
  parameter int unsigned PERI_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   exe_req,
  input  logic                   exe_w_en,
  input  logic [2:0]             exe_funct3,
  input  logic [31:0]            exe_addr,
  input  logic [31:0]            exe_w_data,
  output logic                   lsu_stall,
  output logic                   lsu_done,
  output logic [31:0]            lsu_r_data,
  output logic                   lsu_misalign,
  output logic                   lsu_bus_err,
  lsu_dbus_ctrl_if.master        dbus
);

  localparam int unsigned     CNT_W    = $clog2(PERI_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERI_TIMEOUT - 1);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  type_lsu_states_e state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             w_en_q, w_en_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_busy_q, seen_busy_d;
  logic [31:0]      r_data_q, r_data_d;
  logic             err_q, err_d;
  logic             mis_q, mis_d;

  logic [3:0]       sel_byte;
  logic [31:0]      w_data_sh;
  logic [31:0]      r_data_ext;
  logic             dmem_hit;
  logic             busy;
  logic             complete;
  type_dbus2peri_s  bus_o;

  lsu_dbus_ctrl_align u_align (
    .funct3_i   (funct3_q),
    .a_i        (addr_q[1:0]),
    .w_data_i   (w_data_q),
    .r_data_i   (dbus.dbus2lsu_i.r_data),
    .sel_byte_o (sel_byte),
    .w_data_o   (w_data_sh),
    .r_data_o   (r_data_ext)
  );

  assign dmem_hit = (addr_q & DMEM_MASK) == DMEM_BASE;
  assign busy     = (state_q == LSU_BUSY);

  // Dmem stores finish on the WRITE cycle (busy seen, now low); everything else finishes on ack.
  always_comb begin
    if (w_en_q && dmem_hit) complete = seen_busy_q && !dbus.store_busy;
    else                    complete = dbus.dbus2lsu_i.ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      w_en_q      <= 1'b0;
      w_data_q    <= '0;
      cnt_q       <= '0;
      seen_busy_q <= 1'b0;
      r_data_q    <= '0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      w_en_q      <= w_en_d;
      w_data_q    <= w_data_d;
      cnt_q       <= cnt_d;
      seen_busy_q <= seen_busy_d;
      r_data_q    <= r_data_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    w_en_d      = w_en_q;
    w_data_d    = w_data_q;
    cnt_d       = cnt_q;
    seen_busy_d = seen_busy_q;
    r_data_d    = r_data_q;
    err_d       = err_q;
    mis_d       = mis_q;
    lsu_stall   = 1'b0;
    lsu_done    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        lsu_stall = exe_req;
        if (exe_req) begin
          addr_d      = TRAP_EN ? exe_addr : lsu_force_align(exe_funct3, exe_addr);
          funct3_d    = exe_funct3;
          w_en_d      = exe_w_en;
          w_data_d    = exe_w_data;
          cnt_d       = '0;
          seen_busy_d = 1'b0;
          r_data_d    = '0;
          err_d       = 1'b0;
          mis_d       = 1'b0;
          state_d     = LSU_BUSY;
          if (lsu_illegal(exe_w_en, exe_funct3)) begin
            err_d   = 1'b1;
            state_d = LSU_RESP;
          end else if (TRAP_EN && lsu_misaligned(exe_funct3, exe_addr[1:0])) begin
            mis_d   = 1'b1;
            state_d = LSU_RESP;
          end
        end
      end
      LSU_BUSY: begin
        lsu_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (dbus.store_busy) seen_busy_d = 1'b1;
        if (complete) begin
          if (!w_en_q) r_data_d = r_data_ext;
          state_d = LSU_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = LSU_RESP;
        end
      end
      LSU_RESP: begin
        lsu_done = 1'b1;
        state_d  = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    bus_o = '0;
    if (busy) begin
      bus_o.req      = 1'b1;
      bus_o.addr     = addr_q;
      bus_o.w_data   = w_data_sh;
      bus_o.sel_byte = sel_byte;
      bus_o.w_en     = w_en_q;
    end
  end

  assign dbus.lsu2dbus_o = bus_o;
  assign dbus.dmem_sel   = busy && dmem_hit;

  // Results are only presented alongside lsu_done.
  assign lsu_r_data   = lsu_done ? r_data_q : 32'd0;
  assign lsu_bus_err  = lsu_done && err_q;
  assign lsu_misalign = lsu_done && mis_q;

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// tb/tb_lsu_dbus_ctrl.sv - vector-table bench for lsu_dbus_ctrl with dmem RMW and peripheral models
module tb_lsu_dbus_ctrl;
  import lsu_dbus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exe_req = 1'b0;
  logic        exe_w_en = 1'b0;
  logic [2:0]  exe_funct3 = 3'b000;
  logic [31:0] exe_addr = 32'd0;
  logic [31:0] exe_w_data = 32'd0;
  logic        lsu_stall, lsu_done, lsu_misalign, lsu_bus_err;
  logic [31:0] lsu_r_data;

  lsu_dbus_ctrl_if bus ();

  lsu_dbus_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exe_req      (exe_req),
    .exe_w_en     (exe_w_en),
    .exe_funct3   (exe_funct3),
    .exe_addr     (exe_addr),
    .exe_w_data   (exe_w_data),
    .lsu_stall    (lsu_stall),
    .lsu_done     (lsu_done),
    .lsu_r_data   (lsu_r_data),
    .lsu_misalign (lsu_misalign),
    .lsu_bus_err  (lsu_bus_err),
    .dbus         (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] peri_rdata = 32'd0;
  int          ack_dly = 0;
  int          busy_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cyc <= 0;
    else if (bus.lsu2dbus_o.req) busy_cyc <= busy_cyc + 1;
    else busy_cyc <= 0;
  end

  // 3-cycle RMW memory: busy, busy, then write at the end of the third request cycle.
  always @(posedge clk) begin
    if (rst_n && bus.lsu2dbus_o.req && bus.lsu2dbus_o.w_en && bus.dmem_sel && busy_cyc == 2) begin
      for (int b = 0; b < 4; b++)
        if (bus.lsu2dbus_o.sel_byte[b])
          mem[bus.lsu2dbus_o.addr[9:2]][8*b +: 8] <= bus.lsu2dbus_o.w_data[8*b +: 8];
    end
  end

  always_comb begin
    bus.store_busy = bus.lsu2dbus_o.req && bus.lsu2dbus_o.w_en && bus.dmem_sel && (busy_cyc < 2);
    bus.dbus2lsu_i = '{r_data: (bus.dmem_sel ? mem[bus.lsu2dbus_o.addr[9:2]] : peri_rdata),
                       ack: bus.lsu2dbus_o.req &&
                            ((bus.dmem_sel && !bus.lsu2dbus_o.w_en) ||
                             (!bus.dmem_sel && busy_cyc >= ack_dly))};
  end

  typedef struct {
    string       name;
    logic        w_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] peri;
    int          dly;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    logic        rq;
    logic [3:0]  sel;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(string n, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] wdat,
                              logic [31:0] p, int d, int l, logic [31:0] rd, logic e, logic m,
                              logic r, logic [3:0] s, logic [31:0] wo);
    vec_t v;
    v.name = n; v.w_en = w; v.f3 = f; v.addr = a; v.wdata = wdat; v.peri = p; v.dly = d;
    v.lat = l; v.rdata = rd; v.err = e; v.mis = m; v.rq = r; v.sel = s; v.wd = wo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_access(input vec_t v);
    logic        got, rq, stall_bad;
    logic [3:0]  sel;
    logic [31:0] wd, rd;
    logic        err, mis;
    int          lat;
    got = 0; rq = 0; stall_bad = 0; sel = 0; wd = 0; rd = 0; err = 0; mis = 0; lat = -1;
    ack_dly = v.dly; peri_rdata = v.peri;
    @(posedge clk); #1;
    exe_req = 1'b1; exe_w_en = v.w_en; exe_funct3 = v.f3; exe_addr = v.addr; exe_w_data = v.wdata;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (bus.lsu2dbus_o.req) begin
        rq = 1; sel = bus.lsu2dbus_o.sel_byte; wd = bus.lsu2dbus_o.w_data;
      end
      if (lsu_done) begin
        got = 1; lat = c; rd = lsu_r_data; err = lsu_bus_err; mis = lsu_misalign;
        if (lsu_stall) stall_bad = 1;
      end else begin
        if (!lsu_stall) stall_bad = 1;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    exe_req = 1'b0;
    @(posedge clk); #1;
    chk({v.name, ".latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, ".r_data"}, rd, v.rdata);
    chk({v.name, ".bus_err"}, 32'(err), 32'(v.err));
    chk({v.name, ".misalign"}, 32'(mis), 32'(v.mis));
    chk({v.name, ".req_seen"}, 32'(rq), 32'(v.rq));
    chk({v.name, ".stall"}, 32'(stall_bad), 32'd0);
    if (v.rq) chk({v.name, ".sel_byte"}, 32'(sel), 32'(v.sel));
    if (v.rq && v.w_en) chk({v.name, ".w_data"}, wd, v.wd);
  endtask

  logic [31:0] exp_word;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    //             name      w  f3      addr          wdata         peri          dly   lat rdata         e  m  rq sel    wd
    vecs.push_back(mk("sw100",  1, LSU_SW,  32'h100,      32'h1234_5678, 0,            0,    4, 32'd0,         0, 0, 1, 4'hF, 32'h1234_5678));
    vecs.push_back(mk("lw100",  0, LSU_LW,  32'h100,      0,             0,            0,    2, 32'h1234_5678, 0, 0, 1, 4'hF, 0));
    vecs.push_back(mk("sb101",  1, LSU_SB,  32'h101,      32'h0000_00AB, 0,            0,    4, 32'd0,         0, 0, 1, 4'h2, 32'h0000_AB00));
    vecs.push_back(mk("lw100b", 0, LSU_LW,  32'h100,      0,             0,            0,    2, 32'h1234_AB78, 0, 0, 1, 4'hF, 0));
    vecs.push_back(mk("sw80ff", 1, LSU_SW,  32'h100,      32'h80FF_0000, 0,            0,    4, 32'd0,         0, 0, 1, 4'hF, 32'h80FF_0000));
    vecs.push_back(mk("lh102",  0, LSU_LH,  32'h102,      0,             0,            0,    2, 32'hFFFF_80FF, 0, 0, 1, 4'hC, 0));
    vecs.push_back(mk("lhu102", 0, LSU_LHU, 32'h102,      0,             0,            0,    2, 32'h0000_80FF, 0, 0, 1, 4'hC, 0));
    vecs.push_back(mk("lb103",  0, LSU_LB,  32'h103,      0,             0,            0,    2, 32'hFFFF_FF80, 0, 0, 1, 4'h8, 0));
    vecs.push_back(mk("lbu103", 0, LSU_LBU, 32'h103,      0,             0,            0,    2, 32'h0000_0080, 0, 0, 1, 4'h8, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lw102",  0, LSU_LW,  32'h102,      0,             0,            0,    1, 32'd0,         0, 1, 0, 4'h0, 0));
`else
    vecs.push_back(mk("lw102",  0, LSU_LW,  32'h102,      0,             0,            0,    2, 32'h80FF_0000, 0, 0, 1, 4'hF, 0));
`endif
    vecs.push_back(mk("ill_ld", 0, 3'b011,  32'h100,      0,             0,            0,    1, 32'd0,         1, 0, 0, 4'h0, 0));
    vecs.push_back(mk("ill_st", 1, 3'b101,  32'h100,      32'hFFFF_FFFF, 0,            0,    1, 32'd0,         1, 0, 0, 4'h0, 0));
    vecs.push_back(mk("lw100c", 0, LSU_LW,  32'h100,      0,             0,            0,    2, 32'h80FF_0000, 0, 0, 1, 4'hF, 0));
    vecs.push_back(mk("sh102",  1, LSU_SH,  32'h102,      32'h0000_BEEF, 0,            0,    4, 32'd0,         0, 0, 1, 4'hC, 32'hBEEF_0000));
    vecs.push_back(mk("lw100d", 0, LSU_LW,  32'h100,      0,             0,            0,    2, 32'hBEEF_0000, 0, 0, 1, 4'hF, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("sh103",  1, LSU_SH,  32'h103,      32'h0000_1234, 0,            0,    1, 32'd0,         0, 1, 0, 4'h0, 0));
    vecs.push_back(mk("lw100e", 0, LSU_LW,  32'h100,      0,             0,            0,    2, 32'hBEEF_0000, 0, 0, 1, 4'hF, 0));
`else
    vecs.push_back(mk("sh103",  1, LSU_SH,  32'h103,      32'h0000_1234, 0,            0,    4, 32'd0,         0, 0, 1, 4'hC, 32'h1234_0000));
    vecs.push_back(mk("lw100e", 0, LSU_LW,  32'h100,      0,             0,            0,    2, 32'h1234_0000, 0, 0, 1, 4'hF, 0));
`endif
    vecs.push_back(mk("p_lw",   0, LSU_LW,  32'h8000_0000, 0,            32'hCAFE_F00D, 0,   2, 32'hCAFE_F00D, 0, 0, 1, 4'hF, 0));
    vecs.push_back(mk("p_lb",   0, LSU_LB,  32'h8000_0001, 0,            32'hCAFE_F00D, 0,   2, 32'hFFFF_FFF0, 0, 0, 1, 4'h2, 0));
    vecs.push_back(mk("p_lhu",  0, LSU_LHU, 32'h8000_0002, 0,            32'hCAFE_F00D, 3,   5, 32'h0000_CAFE, 0, 0, 1, 4'hC, 0));
    vecs.push_back(mk("p_sb",   1, LSU_SB,  32'h8000_0003, 32'h0000_0055, 0,           0,    2, 32'd0,         0, 0, 1, 4'h8, 32'h5500_0000));
    vecs.push_back(mk("p_tmo",  0, LSU_LW,  32'h8000_0000, 0,            32'hCAFE_F00D, 1000, 17, 32'd0,       1, 0, 1, 4'hF, 0));
    vecs.push_back(mk("p_last", 0, LSU_LW,  32'h8000_0000, 0,            32'hCAFE_F00D, 15,  17, 32'hCAFE_F00D, 0, 0, 1, 4'hF, 0));
    vecs.push_back(mk("p_late", 0, LSU_LW,  32'h8000_0000, 0,            32'hCAFE_F00D, 16,  17, 32'd0,        1, 0, 1, 4'hF, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(lsu_stall), 32'd0);
    chk("rst.done", 32'(lsu_done), 32'd0);
    chk("rst.r_data", lsu_r_data, 32'd0);
    chk("rst.flags", {30'd0, lsu_misalign, lsu_bus_err}, 32'd0);
    chk("rst.bus", {bus.lsu2dbus_o.req, bus.lsu2dbus_o.sel_byte, bus.lsu2dbus_o.w_en, bus.dmem_sel},
        32'd0);
    chk("rst.addr", bus.lsu2dbus_o.addr, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_access(vecs[i]);

    // Reset during the BUSY phase of a dmem store: no write, no done, bus drops immediately.
`ifdef LSU_MISALIGN_TRAP_EN
    exp_word = 32'hBEEF_0000;
`else
    exp_word = 32'h1234_0000;
`endif
    ack_dly = 0;
    @(posedge clk); #1;
    exe_req = 1'b1; exe_w_en = 1'b1; exe_funct3 = LSU_SW; exe_addr = 32'h100; exe_w_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("mid.req_before", 32'(bus.lsu2dbus_o.req), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0; exe_req = 1'b0;
    #1;
    chk("mid.req", 32'(bus.lsu2dbus_o.req), 32'd0);
    chk("mid.dmem_sel", 32'(bus.dmem_sel), 32'd0);
    chk("mid.stall_done", {30'd0, lsu_stall, lsu_done}, 32'd0);
    chk("mid.w_data", bus.lsu2dbus_o.w_data, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid.done_held", 32'(lsu_done), 32'd0);
    rst_n = 1'b1;
    chk("mid.mem", mem[8'h40], exp_word);
    run_access(mk("post_rst", 0, LSU_LW, 32'h100, 0, 0, 0, 2, exp_word, 0, 0, 1, 4'hF, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
